// File: rtl/adder_sched_pkg.sv
// Shared defaults and tag types for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned N_REQ_DEF = 4;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr (modulo N_REQ) and owns the ptr register.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     handshake,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] ptr;

  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // ptr+k is below 2*N_REQ, so one conditional subtract gives the modulo
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found                = 1'b1;
        gnt[idx[ID_W-1:0]]   = 1'b1;
        gnt_id               = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one pipelined adder among N_REQ requesters; routes each sum back by a tag
// that travels alongside the adder pipeline.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*WIDTH-1:0]       req_a,
  input  logic [N_REQ*WIDTH-1:0]       req_b,
  output logic                         add_valid,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  input  logic [WIDTH:0]               add_c,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [WIDTH:0]               rsp_c,
  output logic [$clog2(ADD_LAT+1):0]   inflight
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } stage_t;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             hs;
  stage_t           tag [ADD_LAT];
  stage_t           last;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .handshake (hs),
    .gnt       (gnt),
    .gnt_id    (gnt_id)
  );

  assign req_ready = rst ? gnt : '0;
  assign add_valid = rst & (|req_valid);
  assign hs        = |(req_valid & req_ready);
  assign add_a     = add_valid ? req_a[gnt_id*WIDTH +: WIDTH] : '0;
  assign add_b     = add_valid ? req_b[gnt_id*WIDTH +: WIDTH] : '0;
  assign last      = tag[ADD_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ADD_LAT; i++) tag[i] <= '0;
      rsp_valid <= '0;
      rsp_c     <= '0;
      inflight  <= '0;
    end else begin
      tag[0].v  <= hs;
      tag[0].id <= gnt_id;
      for (int unsigned i = 1; i < ADD_LAT; i++) tag[i] <= tag[i-1];
      rsp_valid <= '0;
      if (last.v) begin
        rsp_valid[last.id] <= 1'b1;
        rsp_c              <= add_c;
      end
      case ({hs, last.v})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: external adder model, queue-based reference model,
// directed literal checks and a randomized scoreboard run.
module tb_adder_rr_sched;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int CW  = $clog2(LAT+1)+1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             add_valid;
  logic [W-1:0]     add_a, add_b;
  logic [W:0]       add_c;
  logic [N-1:0]     rsp_valid;
  logic [W:0]       rsp_c;
  logic [CW-1:0]    inflight;

  always #5 clk = ~clk;

  adder_rr_sched #(
    .WIDTH   (W),
    .N_REQ   (N),
    .ADD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_valid (add_valid),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .rsp_valid (rsp_valid),
    .rsp_c     (rsp_c),
    .inflight  (inflight)
  );

  // The shared adder sitting beside the scheduler: LAT-stage pipeline, full-width sum.
  logic [W:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_c = apipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: each granted op leaves the scheduler exactly LAT edges after its handshake edge.
  typedef struct {
    int         id;
    logic [W:0] sum;
    longint     ret;
  } op_t;

  op_t        q[$];
  int         m_ptr = 0;
  longint     edge_n = 0;
  logic [N-1:0] m_rsp_valid = '0;
  logic [W:0] m_rsp_c = '0;
  int         issued [N];
  int         got [N];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int g;
    if (!rst) begin
      q.delete();
      m_ptr       = 0;
      m_rsp_valid = '0;
      m_rsp_c     = '0;
    end else begin
      edge_n++;
      m_rsp_valid = '0;
      if (q.size() > 0 && q[0].ret == edge_n) begin
        m_rsp_valid[q[0].id] = 1'b1;
        m_rsp_c              = q[0].sum;
        void'(q.pop_front());
      end
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        q.push_back(op_t'{g, {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]}, edge_n + LAT});
        issued[g]++;
        m_ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [N-1:0] er;
    logic [W-1:0] ea, eb;
    g  = rst ? pick(req_valid, m_ptr) : -1;
    er = '0;
    ea = '0;
    eb = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ea    = req_a[g*W +: W];
      eb    = req_b[g*W +: W];
    end
    chk("req_ready", req_ready, er);
    chk("add_valid", add_valid, g >= 0);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_c", rsp_c, m_rsp_c);
    chk("inflight", inflight, q.size());
    chk("inflight_bound", inflight <= CW'(LAT+1), 1'b1);
    for (int i = 0; i < N; i++) if (rsp_valid[i]) got[i]++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] t4_exp [3] = '{4'b0001, 4'b0010, 4'b0001};

  initial begin : main
    logic [N-1:0] taken;
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      got[i]    = 0;
    end

    // Reset with every requester asking.
    req_valid = '1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_add_valid", add_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_inflight", inflight, 0);

    // All requesters valid: strict rotation, sums routed home.
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i);
      req_b[i*W +: W] = W'(10*i);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      @(negedge clk);
      if (c < 8) chk("rotate_grant", req_ready, 4'b0001 << (c % 4));
      if (c >= LAT+1) begin
        chk("rotate_rsp_valid", rsp_valid, 4'b0001 << ((c-LAT-1) % 4));
        chk("rotate_rsp_c", rsp_c, 11 * ((c-LAT-1) % 4));
      end
      next_cycle();
    end

    // Single requester back-to-back with carry out.
    req_valid       = 4'b0100;
    req_a[2*W +: W] = 8'hFF;
    req_b[2*W +: W] = 8'h01;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("single_grant", req_ready, 4'b0100);
      if (c >= LAT+1) begin
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rsp_c", rsp_c, 9'h100);
      end
      next_cycle();
    end
    req_valid = '0;
    repeat (3) next_cycle();

    // ptr now sits at 3: wrap and skip with no idle cycles.
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wrap_grant", req_ready, t4_exp[c]);
      chk("wrap_add_valid", add_valid, 1'b1);
      next_cycle();
    end
    req_valid = '0;
    repeat (3) next_cycle();

    // Reset one cycle after a handshake drops the in-flight result.
    req_valid = 4'b0001;
    next_cycle();
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_rsp_valid", rsp_valid, 4'b0000);
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst_rsp_valid", rsp_valid, 4'b0000);
      chk("postrst_inflight", inflight, 0);
      next_cycle();
    end

    // Randomized traffic, including requesters withdrawing before their grant.
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      got[i]    = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !taken[i]) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          req_valid[i]    = 1'b1;
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (LAT + 3) next_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("scoreboard_count_%0d", i), got[i], issued[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
